// File: rtl/random_pool_reader.sv
// -----------------------------------------------------------------------------
// random_pool_reader
//
// Consumer side of the AC97 entropy pool. It watches the same sample_ready
// level the extractor edge-detects and counts fresh samples mixed into the
// pool since the last readout. On request it waits until the pool has been
// fully refreshed, snapshots it, and streams the snapshot out LSB-byte-first
// over a valid/ready byte interface.
//
// Ports:
//   clock        system clock
//   reset_n      synchronous, active-low reset
//   pool         live entropy pool from the extractor
//   sample_ready AC97 ready level (rising edge = one sample mixed in)
//   req          one-cycle pulse requesting a fresh pool readout
//   byte_data    current output byte (snapshot bits [7:0])
//   byte_valid   byte_data valid (high throughout SEND)
//   byte_ready   consumer accepts the byte when high together with byte_valid
//   busy         high while waiting for freshness or sending
//   done         one-cycle pulse after the last byte has been accepted
//   fresh        fresh-sample counter has reached MIN_FRESH
// -----------------------------------------------------------------------------
module random_pool_reader #(
  parameter int POOL_WIDTH = 256,
  parameter int MIN_FRESH  = 256,
  parameter int CNT_WIDTH  = 9
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [POOL_WIDTH-1:0] pool,
  input  logic                  sample_ready,
  input  logic                  req,
  output logic [7:0]            byte_data,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  fresh
);

  localparam int NUM_BYTES = POOL_WIDTH / 8;
  localparam int IDX_WIDTH = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [CNT_WIDTH-1:0] FRESH_MAX = CNT_WIDTH'(MIN_FRESH);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                  state_q, state_d;
  logic                    ready_q, ready_d;
  logic [CNT_WIDTH-1:0]    cnt_q,   cnt_d;
  logic                    fresh_q, fresh_d;
  logic [IDX_WIDTH-1:0]    idx_q,   idx_d;
  logic                    done_q,  done_d;
  logic [POOL_WIDTH-1:0]   shift_q, shift_d;

  logic                    sample_edge;
  logic                    snapshot;

  // ---------------------------------------------------------------------------
  // Edge detect on the AC97 ready level; one rising edge = one mixed sample.
  // ---------------------------------------------------------------------------
  assign sample_edge = sample_ready & ~ready_q;
  assign ready_d     = sample_ready;

  // ---------------------------------------------------------------------------
  // Readout FSM and snapshot shift register
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d  = state_q;
    shift_d  = shift_q;
    idx_d    = idx_q;
    done_d   = 1'b0;
    snapshot = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (fresh_q) begin
            snapshot = 1'b1;
            state_d  = ST_SEND;
          end else begin
            state_d  = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        // Further requests are redundant here; only freshness matters.
        if (fresh_q) begin
          snapshot = 1'b1;
          state_d  = ST_SEND;
        end
      end

      ST_SEND: begin
        if (byte_ready) begin
          shift_d = shift_q >> 8;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + IDX_WIDTH'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (snapshot) begin
      shift_d = pool;
      idx_d   = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Fresh-sample counter. A sample arriving in the snapshot cycle is mixed by
  // the extractor after the copy was taken, so it already counts toward the
  // next readout.
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (snapshot) begin
      cnt_d = CNT_WIDTH'(sample_edge);
    end else if (sample_edge && (cnt_q != FRESH_MAX)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
    // Registered from the next count so fresh always matches the counter.
    fresh_d = (cnt_d == FRESH_MAX);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of every other flop.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      cnt_q   <= '0;
      fresh_q <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      cnt_q   <= cnt_d;
      fresh_q <= fresh_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // NOTE: the snapshot register is a wide datapath that is always loaded
  // before it is observed and byte_data is gated outside SEND, so it carries
  // no reset.
  always_ff @(posedge clock) begin
    shift_q <= shift_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign byte_valid = (state_q == ST_SEND);
  assign byte_data  = byte_valid ? shift_q[7:0] : 8'h00;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign fresh      = fresh_q;

endmodule

// File: tb/tb_random_pool_reader.sv
// -----------------------------------------------------------------------------
// tb_random_pool_reader
//
// Scoreboard bench for random_pool_reader. A reference model tracks the
// readout mode, the number of sample edges since the last snapshot and the
// bytes owed to the consumer; a separate monitor compares the DUT against it
// on every falling edge and pops expected bytes on each accepted transfer.
// -----------------------------------------------------------------------------
module tb_random_pool_reader;

  localparam int POOL_WIDTH = 256;
  localparam int MIN_FRESH  = 256;
  localparam int CNT_WIDTH  = 9;
  localparam int NBYTES     = POOL_WIDTH / 8;

  logic                  clock;
  logic                  reset_n;
  logic [POOL_WIDTH-1:0] pool;
  logic                  sample_ready;
  logic                  req;
  logic [7:0]            byte_data;
  logic                  byte_valid;
  logic                  byte_ready;
  logic                  busy;
  logic                  done;
  logic                  fresh;

  random_pool_reader #(
    .POOL_WIDTH (POOL_WIDTH),
    .MIN_FRESH  (MIN_FRESH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pool         (pool),
    .sample_ready (sample_ready),
    .req          (req),
    .byte_data    (byte_data),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .busy         (busy),
    .done         (done),
    .fresh        (fresh)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------------------------------------------------------------------
  // Check bookkeeping
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model (updated at each rising edge from the inputs)
  // ---------------------------------------------------------------------------
  typedef enum {M_IDLE, M_WAIT, M_SEND} mmode_e;
  mmode_e     m_mode  = M_IDLE;
  int         m_count = 0;     // sample edges since last snapshot, saturating
  int         m_sent  = 0;     // bytes accepted in the current readout
  bit         m_prev  = 1'b0;  // previous sample_ready level
  bit         m_done  = 1'b0;  // done expected in the current cycle
  int         exp_dones = 0;
  logic [7:0] sb[$];           // bytes owed to the consumer, in order

  task automatic model_step();
    bit edge_s;
    bit is_fresh;
    bit snap;
    if (!reset_n) begin
      m_mode  = M_IDLE;
      m_count = 0;
      m_sent  = 0;
      m_prev  = 1'b0;
      m_done  = 1'b0;
      sb.delete();
      return;
    end
    edge_s   = sample_ready && !m_prev;
    is_fresh = (m_count == MIN_FRESH);
    snap     = (m_mode == M_IDLE && req && is_fresh) || (m_mode == M_WAIT && is_fresh);
    m_done   = 1'b0;
    if (m_mode == M_SEND) begin
      if (byte_ready) begin
        m_sent++;
        if (m_sent == NBYTES) begin
          m_mode = M_IDLE;
          m_done = 1'b1;
          exp_dones++;
        end
      end
    end else if (snap) begin
      for (int i = 0; i < NBYTES; i++) sb.push_back(pool[8*i +: 8]);
      m_mode = M_SEND;
      m_sent = 0;
    end else if (m_mode == M_IDLE && req) begin
      m_mode = M_WAIT;
    end
    if (snap) m_count = edge_s ? 1 : 0;
    else if (edge_s && m_count < MIN_FRESH) m_count++;
    m_prev = sample_ready;
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  // ---------------------------------------------------------------------------
  // Monitor (falling edge, away from the active edge)
  // ---------------------------------------------------------------------------
  bit         mon_en    = 1'b0;
  int         dut_dones = 0;
  bit         held_v    = 1'b0;
  logic [7:0] held      = 8'h00;

  initial forever begin
    @(negedge clock);
    if (mon_en) begin
      check("busy", busy, m_mode != M_IDLE);
      check("byte_valid", byte_valid, m_mode == M_SEND);
      check("fresh", fresh, m_count == MIN_FRESH);
      check("done", done, m_done);
      if (held_v && byte_valid) check("byte_hold", byte_data, held);
      held_v = byte_valid && !byte_ready;
      held   = byte_data;
      if (byte_valid && byte_ready) begin
        if (sb.size() == 0) check("sb_nonempty", sb.size() != 0, 1);
        else check("byte_data", byte_data, sb.pop_front());
      end
      if (done) dut_dones++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (inputs change 2 time units after the rising edge)
  // ---------------------------------------------------------------------------
  int       cyc       = 0;
  int       rdy_mode  = 0;   // 0: hold, 1: random, 2: 1,0,0,1 pattern
  bit       rand_pool = 1'b0;
  bit [3:0] pat       = 4'b1001;

  function automatic logic [POOL_WIDTH-1:0] rand_pool_val();
    logic [POOL_WIDTH-1:0] v;
    for (int i = 0; i < POOL_WIDTH/32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  task automatic cycle();
    @(posedge clock);
    #2;
    cyc++;
    if (rdy_mode == 1) byte_ready = 1'($urandom_range(0, 1));
    else if (rdy_mode == 2) byte_ready = pat[cyc % 4];
    if (rand_pool) pool = rand_pool_val();
  endtask

  task automatic edges(input int n);
    for (int i = 0; i < n; i++) begin
      sample_ready = 1'b1;
      cycle();
      sample_ready = 1'b0;
      cycle();
    end
  endtask

  task automatic pulse_req();
    req = 1'b1;
    cycle();
    req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_mode != M_IDLE || busy) && n < budget) begin
      cycle();
      n++;
    end
    check("wait_idle_in_budget", (m_mode == M_IDLE) && !busy, 1);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int d0;
    int n;
    reset_n      = 1'b0;
    pool         = {4{64'h0123456789ABCDEF}};
    sample_ready = 1'b0;
    req          = 1'b0;
    byte_ready   = 1'b1;
    repeat (3) cycle();

    // Reset state
    check("rst_byte_data", byte_data, 8'h00);
    check("rst_byte_valid", byte_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_fresh", fresh, 1'b0);
    mon_en  = 1'b1;
    reset_n = 1'b1;
    cycle();

    // 1: full refresh, immediate readout of a known pattern
    edges(256);
    check("t1_fresh_before_req", fresh, 1'b1);
    pulse_req();
    check("t1_valid_next_cycle", byte_valid, 1'b1);
    check("t1_first_byte", byte_data, 8'hEF);
    wait_idle(100);

    // 2: request before freshness, pool changing while waiting
    edges(10);
    pulse_req();
    check("t2_busy_wait", busy, 1'b1);
    check("t2_no_valid_wait", byte_valid, 1'b0);
    rand_pool = 1'b1;
    edges(246);
    rand_pool = 1'b0;
    wait_idle(100);

    // 3: backpressure 1,0,0,1
    edges(256);
    rdy_mode = 2;
    pulse_req();
    wait_idle(400);
    rdy_mode   = 0;
    byte_ready = 1'b1;

    // 4: snapshot coinciding with a sample edge
    edges(256);
    req          = 1'b1;
    sample_ready = 1'b1;
    cycle();
    req = 1'b0;
    cycle();
    sample_ready = 1'b0;
    cycle();
    edges(254);
    check("t4_fresh_after_255", fresh, 1'b0);
    edges(1);
    check("t4_fresh_after_256", fresh, 1'b1);
    wait_idle(100);

    // 5: reset mid-SEND
    pulse_req();
    n = 0;
    while (m_sent < 5 && n < 100) begin
      cycle();
      n++;
    end
    check("t5_reached_byte5", m_sent, 5);
    d0      = dut_dones;
    reset_n = 1'b0;
    cycle();
    check("t5_rst_valid", byte_valid, 1'b0);
    check("t5_rst_busy", busy, 1'b0);
    check("t5_rst_fresh", fresh, 1'b0);
    reset_n = 1'b1;
    repeat (3) cycle();
    check("t5_no_done", dut_dones, d0);
    pulse_req();
    check("t5_wait_busy", busy, 1'b1);
    check("t5_wait_no_valid", byte_valid, 1'b0);
    edges(256);
    wait_idle(100);

    // 6: long high level counts once; req ignored during SEND
    sample_ready = 1'b1;
    repeat (100) cycle();
    sample_ready = 1'b0;
    cycle();
    edges(254);
    check("t6_fresh_after_255", fresh, 1'b0);
    edges(1);
    check("t6_fresh_after_256", fresh, 1'b1);
    d0 = dut_dones;
    pulse_req();
    n = 0;
    while (m_mode == M_SEND && n < 100) begin
      req = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    req = 1'b0;
    repeat (2) cycle();
    check("t6_one_done", dut_dones - d0, 1);
    check("t6_idle_after", busy, 1'b0);

    // 7: randomized traffic
    rdy_mode  = 1;
    rand_pool = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      sample_ready = 1'($urandom_range(0, 1));
      req          = ($urandom_range(0, 19) == 0);
      cycle();
    end
    req = 1'b0;
    n   = 0;
    while ((m_mode != M_IDLE || busy) && n < 5000) begin
      sample_ready = ~sample_ready;
      cycle();
      n++;
    end
    check("t7_drained", busy, 1'b0);
    rdy_mode  = 0;
    rand_pool = 1'b0;
    repeat (2) cycle();

    check("done_total", dut_dones, exp_dones);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
